// File: rtl/adf4158_cfg_rx.sv
// rtl/adf4158_cfg_rx.sv - ADF4158 serial configuration receiver with 10-slot register shadow
// Oversamples the SPI pins in the clk domain, decodes each latched word into its slot.
module adf4158_cfg_rx #(
  parameter int CLK_RATIO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_clk,
  input  logic        spi_data,
  input  logic        spi_le,
  output logic        word_valid,
  output logic [3:0]  word_idx,
  output logic [31:0] word_data,
  output logic        len_err,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_data,
  output logic [9:0]  written,
  output logic        configured,
  output logic        ramp_en
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

  // Two synchronizer stages plus a history flop cannot resolve spi_clk phases under one clk.
  if (CLK_RATIO < 2) begin : g_clk_ratio_unsupported
  end

  state_t      state_q, state_d;
  logic [1:0]  sclk_sync_q, sclk_sync_d;
  logic [1:0]  sdata_sync_q, sdata_sync_d;
  logic [1:0]  le_sync_q, le_sync_d;
  logic        sclk_prev_q, sclk_prev_d;
  logic        le_prev_q, le_prev_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] slot_q [10];
  logic [31:0] slot_d [10];
  logic [9:0]  written_q, written_d;
  logic        configured_q, configured_d;
  logic        word_valid_q, word_valid_d;
  logic [3:0]  word_idx_q, word_idx_d;
  logic [31:0] word_data_q, word_data_d;
  logic        len_err_q, len_err_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        sclk_rise;
  logic        le_rise;
  logic [3:0]  dec_idx;

  function automatic logic [3:0] decode_slot(input logic [31:0] w);
    logic [3:0] s;
    case (w[2:0])
      3'd5:    s = w[23] ? 4'd5 : 4'd6;
      3'd6:    s = w[23] ? 4'd7 : 4'd8;
      3'd7:    s = 4'd9;
      default: s = {1'b0, w[2:0]};
    endcase
    return s;
  endfunction

  assign sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
  assign le_rise   = le_sync_q[1] & ~le_prev_q;
  assign dec_idx   = decode_slot(shift_q);

  always_comb begin
    state_d      = state_q;
    sclk_sync_d  = {sclk_sync_q[0], spi_clk};
    sdata_sync_d = {sdata_sync_q[0], spi_data};
    le_sync_d    = {le_sync_q[0], spi_le};
    sclk_prev_d  = sclk_sync_q[1];
    le_prev_d    = le_sync_q[1];
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    slot_d       = slot_q;
    written_d    = written_q;
    configured_d = &written_q;
    word_valid_d = 1'b0;
    word_idx_d   = word_idx_q;
    word_data_d  = word_data_q;
    len_err_d    = 1'b0;
    rd_data_d    = (rd_idx < 4'd10) ? slot_q[rd_idx] : 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (!le_sync_q[1]) begin
          state_d = ST_SHIFT;
          shift_d = 32'd0;
          cnt_d   = 6'd0;
        end
      end
      ST_SHIFT: begin
        // A clock edge arriving together with the load edge still belongs to this word.
        if (sclk_rise) begin
          shift_d = {shift_q[30:0], sdata_sync_q[1]};
          cnt_d   = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
        end
        if (le_rise) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        state_d = ST_IDLE;
        if (cnt_q == 6'd32) begin
          slot_d[dec_idx]    = shift_q;
          written_d[dec_idx] = 1'b1;
          word_valid_d       = 1'b1;
          word_idx_d         = dec_idx;
          word_data_d        = shift_q;
        end else begin
          len_err_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sclk_sync_q  <= 2'b00;
      sdata_sync_q <= 2'b00;
      le_sync_q    <= 2'b11;
      sclk_prev_q  <= 1'b0;
      le_prev_q    <= 1'b1;
      shift_q      <= 32'd0;
      cnt_q        <= 6'd0;
      for (int i = 0; i < 10; i++) begin
        slot_q[i] <= 32'd0;
      end
      written_q    <= 10'd0;
      configured_q <= 1'b0;
      word_valid_q <= 1'b0;
      word_idx_q   <= 4'd0;
      word_data_q  <= 32'd0;
      len_err_q    <= 1'b0;
      rd_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= sclk_sync_d;
      sdata_sync_q <= sdata_sync_d;
      le_sync_q    <= le_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      le_prev_q    <= le_prev_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      written_q    <= written_d;
      configured_q <= configured_d;
      word_valid_q <= word_valid_d;
      word_idx_q   <= word_idx_d;
      word_data_q  <= word_data_d;
      len_err_q    <= len_err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign word_valid = word_valid_q;
  assign word_idx   = word_idx_q;
  assign word_data  = word_data_q;
  assign len_err    = len_err_q;
  assign rd_data    = rd_data_q;
  assign written    = written_q;
  assign configured = configured_q;
  assign ramp_en    = slot_q[0][31];

endmodule
